// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO bridge register window.
//   - word offsets of each register group inside the 64-word window
//   - window size
//   - params_ok(): range check for the bridge parameters
package mmio_pkg;

   localparam int WIN_WORDS = 64;

   localparam logic [5:0] OFF_OUT   = 6'h00;
   localparam logic [5:0] OFF_PULSE = 6'h10;
   localparam logic [5:0] OFF_IN    = 6'h20;
   localparam logic [5:0] OFF_EVENT = 6'h30;
   localparam logic [5:0] OFF_MASK  = 6'h31;

   function automatic bit params_ok(input logic [11:0] base,
                                    input int n_out,
                                    input int n_in,
                                    input int n_evt,
                                    input int n_pulse,
                                    input int pulse_len);
      return (base[5:0] == 6'd0)
          && (n_out   >= 1) && (n_out   <= 16)
          && (n_in    >= 1) && (n_in    <= 16)
          && (n_evt   >= 1) && (n_evt   <= 32)
          && (n_pulse >= 1) && (n_pulse <= 32)
          && (pulse_len >= 1) && (pulse_len <= 255);
   endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs.
// Ports:
//   i_clock   system clock
//   i_reset_n asynchronous active-low reset, clears both stages
//   i_d       asynchronous input bus (WIDTH bits)
//   o_q       synchronised output, two edges behind i_d
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: memory-mapped I/O window on the CPU data-memory bus.
// A 64-word window at BASE_ADDR holds output registers, pulse outputs,
// synchronised level inputs and sticky event flags with an interrupt.
// Everything outside the window passes straight through to the data RAM.
// Ports:
//   i_clock, i_reset_n   system clock, asynchronous active-low reset
//   i_bus_we/addr/wdata  CPU store strobe, word address, store data
//   o_bus_rdata          read data to CPU (1-cycle latency, like RAM)
//   o_ram_we             RAM write enable, suppressed inside the window
//   i_ram_rdata          RAM registered read data
//   o_out_data           NUM_OUT 32-bit output registers, packed
//   o_pulse_out          self-clearing pulses, PULSE_LEN cycles wide
//   i_in_data            NUM_IN asynchronous 32-bit level inputs
//   i_evt_in             NUM_EVT asynchronous event inputs
//   o_irq                registered OR of pending & mask
module mmio_io_bridge
   import mmio_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = 12'hFC0,
   parameter int          NUM_OUT   = 2,
   parameter int          NUM_IN    = 1,
   parameter int          NUM_EVT   = 8,
   parameter int          NUM_PULSE = 4,
   parameter int          PULSE_LEN = 1
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_bus_we,
   input  logic [11:0]            i_bus_addr,
   input  logic [31:0]            i_bus_wdata,
   output logic [31:0]            o_bus_rdata,
   output logic                   o_ram_we,
   input  logic [31:0]            i_ram_rdata,
   output logic [32*NUM_OUT-1:0]  o_out_data,
   output logic [NUM_PULSE-1:0]   o_pulse_out,
   input  logic [32*NUM_IN-1:0]   i_in_data,
   input  logic [NUM_EVT-1:0]     i_evt_in,
   output logic                   o_irq
);

   if (!params_ok(BASE_ADDR, NUM_OUT, NUM_IN, NUM_EVT, NUM_PULSE, PULSE_LEN)) begin : g_param_err
      $error("mmio_io_bridge: parameter out of range or BASE_ADDR not 64-aligned");
   end

   localparam logic [7:0] LEN8 = 8'(PULSE_LEN);

   logic                  w_hit;
   logic                  w_wr;
   logic [5:0]            w_off;
   logic [31:0]           r_out [NUM_OUT];
   logic [7:0]            r_pcnt [NUM_PULSE];
   logic [NUM_PULSE-1:0]  w_busy;
   logic [32*NUM_IN-1:0]  w_in_s;
   logic [NUM_EVT-1:0]    w_evt_s;
   logic [NUM_EVT-1:0]    r_evt_prev;
   logic [NUM_EVT-1:0]    w_rise;
   logic [NUM_EVT-1:0]    w_clr;
   logic [NUM_EVT-1:0]    r_pend;
   logic [NUM_EVT-1:0]    r_mask;
   logic                  r_irq;
   logic                  r_rd_hit;
   logic [31:0]           r_rd_data;
   logic [31:0]           w_rd_next;

   assign w_hit    = (i_bus_addr[11:6] == BASE_ADDR[11:6]);
   assign w_off    = i_bus_addr[5:0];
   assign w_wr     = i_bus_we & w_hit;
   assign o_ram_we = i_bus_we & ~w_hit;

   sync2 #(.WIDTH(32*NUM_IN)) u_sync_in (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_d       (i_in_data),
      .o_q       (w_in_s)
   );

   sync2 #(.WIDTH(NUM_EVT)) u_sync_evt (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_d       (i_evt_in),
      .o_q       (w_evt_s)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (w_wr && (w_off == OFF_OUT + 6'(i))) r_out[i] <= i_bus_wdata;
         end
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign o_out_data[32*g +: 32] = r_out[g];
   end

   // A write of 1 reloads the counter even when it is already running,
   // so a retrigger extends the pulse to a full PULSE_LEN from that point.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_PULSE; i++) r_pcnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PULSE; i++) begin
            if (w_wr && (w_off == OFF_PULSE) && i_bus_wdata[i]) begin
               r_pcnt[i] <= LEN8;
            end else if (r_pcnt[i] != 8'd0) begin
               r_pcnt[i] <= r_pcnt[i] - 8'd1;
            end
         end
      end
   end

   always_comb begin
      w_busy = '0;
      for (int i = 0; i < NUM_PULSE; i++) w_busy[i] = (r_pcnt[i] != 8'd0);
   end

   assign o_pulse_out = w_busy;

   // prev resets to 0, so an input already high at reset release is
   // reported as one event.
   assign w_rise = w_evt_s & ~r_evt_prev;
   assign w_clr  = (w_wr && (w_off == OFF_EVENT)) ? i_bus_wdata[NUM_EVT-1:0] : '0;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_evt_prev <= '0;
         r_pend     <= '0;
         r_mask     <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_evt_prev <= w_evt_s;
         // new edge is OR-ed after the clear so a coincident set wins
         r_pend     <= (r_pend & ~w_clr) | w_rise;
         if (w_wr && (w_off == OFF_MASK)) r_mask <= i_bus_wdata[NUM_EVT-1:0];
         r_irq      <= |(r_pend & r_mask);
      end
   end

   assign o_irq = r_irq;

   // Read mux uses pre-edge state, so a read that coincides with a write
   // (including EVENT W1C) returns the old value.
   always_comb begin
      w_rd_next = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (w_off == OFF_OUT + 6'(i)) w_rd_next = r_out[i];
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_off == OFF_IN + 6'(i)) w_rd_next = w_in_s[32*i +: 32];
      end
      if (w_off == OFF_PULSE) w_rd_next[NUM_PULSE-1:0] = w_busy;
      if (w_off == OFF_EVENT) w_rd_next[NUM_EVT-1:0]   = r_pend;
      if (w_off == OFF_MASK)  w_rd_next[NUM_EVT-1:0]   = r_mask;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_hit  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_hit  <= w_hit;
         r_rd_data <= w_rd_next;
      end
   end

   assign o_bus_rdata = r_rd_hit ? r_rd_data : i_ram_rdata;

endmodule

// File: tb/tb_mmio_io_bridge.sv
module tb_mmio_io_bridge;

   localparam logic [11:0] BASE      = 12'hFC0;
   localparam logic [5:0]  BASE_PAGE = 6'h3F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_we = 1'b0;
   logic [11:0] bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        ram_we;
   logic [31:0] ram_rdata;
   logic [63:0] out_data;
   logic [3:0]  pulse_out;
   logic [31:0] in_data = '0;
   logic [7:0]  evt_in = '0;
   logic        irq;

   mmio_io_bridge #(
      .BASE_ADDR (BASE),
      .NUM_OUT   (2),
      .NUM_IN    (1),
      .NUM_EVT   (8),
      .NUM_PULSE (4),
      .PULSE_LEN (3)
   ) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_bus_we    (bus_we),
      .i_bus_addr  (bus_addr),
      .i_bus_wdata (bus_wdata),
      .o_bus_rdata (bus_rdata),
      .o_ram_we    (ram_we),
      .i_ram_rdata (ram_rdata),
      .o_out_data  (out_data),
      .o_pulse_out (pulse_out),
      .i_in_data   (in_data),
      .i_evt_in    (evt_in),
      .o_irq       (irq)
   );

   always #5 clk = ~clk;

   // RAM environment: registered read, old data on read-during-write
   bit [31:0] mem [4096];
   always @(posedge clk) begin
      if (ram_we) mem[bus_addr] <= bus_wdata;
      ram_rdata <= mem[bus_addr];
   end

   // reference model, kept as plain architectural state
   bit [31:0]   m_ram [4096];
   logic [31:0] m_out [2];
   logic [7:0]  m_pend;
   logic [7:0]  m_mask;
   logic [3:0]  m_busy;
   logic [31:0] m_in;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   int  total = 0;
   int  bad   = 0;
   bit  rd_issue = 1'b0;
   logic [11:0] ram_set [4] = '{12'h010, 12'h123, 12'h7FF, 12'hFBF};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [11:0] a);
      logic [5:0] off;
      off = a[5:0];
      if (a[11:6] != BASE_PAGE) return m_ram[a];
      if (off < 6'd2) return m_out[off[0]];
      case (off)
         6'h10:   return {28'd0, m_busy};
         6'h20:   return m_in;
         6'h30:   return {24'd0, m_pend};
         6'h31:   return {24'd0, m_mask};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_out[0] = '0;
      m_out[1] = '0;
      m_pend   = '0;
      m_mask   = '0;
      m_busy   = '0;
   endtask

   // all bus tasks start and end on a falling edge
   task automatic bus_read(input logic [11:0] a, input string name);
      sb_q.push_back('{exp: exp_read(a), name: name});
      bus_addr = a;
      bus_we   = 1'b0;
      rd_issue = 1'b1;
      @(negedge clk);
      rd_issue = 1'b0;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input string name);
      logic hit;
      hit = (a[11:6] == BASE_PAGE);
      sb_q.push_back('{exp: exp_read(a), name: {name, "_rd"}});
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      rd_issue  = 1'b1;
      #1 chk({name, "_ram_we"}, 64'(ram_we), 64'(!hit));
      @(negedge clk);
      bus_we   = 1'b0;
      rd_issue = 1'b0;
      if (hit) begin
         if (a[5:0] < 6'd2) m_out[a[0]] = d;
         else if (a[5:0] == 6'h30) m_pend = m_pend & ~d[7:0];
         else if (a[5:0] == 6'h31) m_mask = d[7:0];
      end else begin
         m_ram[a] = d;
      end
   endtask

   // monitor: every issued access is compared after the edge that samples it
   always @(posedge clk) begin
      if (rd_issue) begin
         sb_t e;
         #1;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got no expected entry want one at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk({"rd_", e.name}, 64'(bus_rdata), 64'(e.exp));
         end
      end
   end

   initial begin
      model_reset();
      m_in = '0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out", out_data, 64'd0);
      chk("rst_pulse", 64'(pulse_out), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      chk("rst_rdata", 64'(bus_rdata), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      bus_write(BASE + 12'd1, 32'hDEADBEEF, "out1");
      chk("out1_vis", 64'(out_data[63:32]), 64'hDEADBEEF);
      bus_read(BASE + 12'd1, "out1");

      bus_write(12'h010, 32'hCAFE0010, "ram010");
      bus_read(12'h010, "ram010");

      for (int n = 0; n < 80; n++) begin
         logic [11:0] a;
         logic [31:0] d;
         case ($urandom_range(0, 3))
            0:       a = BASE | 12'($urandom_range(0, 63));
            1:       a = BASE | 12'($urandom_range(0, 1));
            default: a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 12'hFBF))
                                                     : ram_set[$urandom_range(0, 3)];
         endcase
         d = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            if (a[11:6] == BASE_PAGE && a[5:0] == 6'h10) a[0] = 1'b1;
            bus_write(a, d, "rnd_w");
         end else begin
            bus_read(a, "rnd_r");
         end
      end
      chk("out_all", out_data, {m_out[1], m_out[0]});
      bus_read(BASE + 12'h03F, "unmapped3f");

      in_data = 32'h12345678;
      @(negedge clk);
      bus_read(BASE + 12'h020, "in_early");
      m_in = 32'h12345678;
      bus_read(BASE + 12'h020, "in_sync");

      bus_write(BASE + 12'h010, 32'h5, "pulse5");
      chk("pulse5_c1", 64'(pulse_out), 64'h5);
      @(negedge clk);
      chk("pulse5_c2", 64'(pulse_out), 64'h5);
      @(negedge clk);
      chk("pulse5_c3", 64'(pulse_out), 64'h5);
      @(negedge clk);
      chk("pulse5_c4", 64'(pulse_out), 64'h0);

      bus_write(BASE + 12'h010, 32'h2, "pulse2");
      m_busy = 4'h2;
      bus_read(BASE + 12'h010, "busy2");
      m_busy = 4'h0;
      repeat (3) @(negedge clk);
      bus_read(BASE + 12'h010, "busy_idle");

      bus_write(BASE + 12'h010, 32'h1, "retrig_a");
      chk("retrig_c1", 64'(pulse_out), 64'h1);
      @(negedge clk);
      chk("retrig_c2", 64'(pulse_out), 64'h1);
      m_busy = 4'h1;
      bus_write(BASE + 12'h010, 32'h1, "retrig_b");
      m_busy = 4'h0;
      chk("retrig_c3", 64'(pulse_out), 64'h1);
      @(negedge clk);
      chk("retrig_c4", 64'(pulse_out), 64'h1);
      @(negedge clk);
      chk("retrig_c5", 64'(pulse_out), 64'h1);
      @(negedge clk);
      chk("retrig_c6", 64'(pulse_out), 64'h0);

      bus_write(BASE + 12'h031, 32'h08, "mask");
      evt_in[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_read(BASE + 12'h030, "evt_edge3");
      m_pend = 8'h08;
      chk("irq_lag", 64'(irq), 64'd0);
      bus_read(BASE + 12'h030, "evt_set");
      chk("irq_set", 64'(irq), 64'd1);
      bus_write(BASE + 12'h030, 32'h08, "w1c");
      chk("irq_hold", 64'(irq), 64'd1);
      @(negedge clk);
      chk("irq_clr", 64'(irq), 64'd0);
      bus_read(BASE + 12'h030, "evt_clr");

      evt_in[3] = 1'b0;
      repeat (4) @(negedge clk);
      evt_in[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_write(BASE + 12'h030, 32'h08, "w1c_race");
      m_pend = m_pend | 8'h08;
      bus_read(BASE + 12'h030, "set_wins");
      chk("irq_race", 64'(irq), 64'd1);
      bus_write(BASE + 12'h030, 32'hFF, "w1c_all");
      @(negedge clk);
      chk("irq_all_clr", 64'(irq), 64'd0);
      bus_read(BASE + 12'h030, "evt_level_no_edge");

      bus_write(BASE + 12'h010, 32'hF, "pulse_f");
      chk("pulse_f_c1", 64'(pulse_out), 64'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_pulse", 64'(pulse_out), 64'h0);
      chk("rst_mid_out", out_data, 64'd0);
      chk("rst_mid_irq", 64'(irq), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      m_pend = 8'h08;
      bus_read(BASE + 12'h030, "evt_held_thru_rst");
      bus_read(BASE + 12'h001, "out1_after_rst");
      chk("irq_masked_after_rst", 64'(irq), 64'd0);

      repeat (3) @(negedge clk);
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_io_bridge.md
# mmio_io_bridge

Parametrised memory-mapped I/O bridge on the processor data-memory bus, between the CPU's dmem port and the data RAM. It generalises the fixed player/start/eoc register taps into a decoded 64-word register window with N output registers, self-timed pulse outputs, synchronised level inputs and sticky edge-captured event inputs with an interrupt line. Accesses outside the window pass through to RAM unchanged.

## Interface
- BASE_ADDR, 12'hFC0: word address of the 64-word window; must be 64-aligned.
- NUM_OUT, 2: 32-bit output registers, 1..16.
- NUM_IN, 1: 32-bit level inputs, 1..16.
- NUM_EVT, 8: single-bit event inputs, 1..32.
- NUM_PULSE, 4: pulse outputs, 1..32.
- PULSE_LEN, 1: pulse width in cycles, 1..255.

- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- bus_we  in  1  CPU store strobe (dmem wren).
- bus_addr  in  12  CPU word address.
- bus_wdata  in  32  CPU store data.
- bus_rdata  out  32  read data to CPU (q_dmem).
- ram_we  out  1  write enable to RAM, bus_we gated off inside window.
- ram_rdata  in  32  RAM read data (1-cycle registered read).
- out_data  out  32*NUM_OUT  output registers, channel i at [32i+31:32i].
- pulse_out  out  NUM_PULSE  self-clearing pulses.
- in_data  in  32*NUM_IN  asynchronous level inputs.
- evt_in  in  NUM_EVT  asynchronous event inputs.
- irq  out  1  OR of pending & enabled events.

## Operation
- hit = bus_addr[11:6] == BASE_ADDR[11:6]; off = bus_addr[5:0].
- ram_we = bus_we & ~hit (combinational). RAM always sees the address.
- Map: off 0x00..NUM_OUT-1 OUT[i] RW. 0x10 PULSE: write sets pulses for bits=1; read returns busy bits. 0x20..0x20+NUM_IN-1 IN[i] RO, synchronised value. 0x30 EVENT: read pending, write-1-to-clear. 0x31 MASK RW, NUM_EVT bits. Other offsets read 0, writes ignored. Unused high bits read 0.
- Pulse i: write 1 loads counter with PULSE_LEN; pulse_out[i] = (count != 0); decrements each cycle. Write 1 while busy restarts at PULSE_LEN (retrigger). Writing 0 has no effect.
- Inputs: in_data and evt_in pass through two-flop synchronisers. Event i goes pending on a 0->1 transition of its synchronised value (compared to a previous-value flop).
- Same-cycle set and W1C clear of one event bit: set wins, bit stays 1.
- irq = |(pending & mask), registered.
- Reset: out_data, pulse counters, sync/prev flops, pending, mask, irq, read register all 0. Because prev resets to 0, an evt_in held high through reset release records one event.

## Timing
- Write: effective on the edge with bus_we=1 and hit; out_data/MASK visible the next cycle; pulse_out rises the next cycle and stays high exactly PULSE_LEN cycles.
- Read: address sampled at edge k; bus_rdata valid after edge k, same as RAM. hit is registered with the read data; bus_rdata = hit_q ? reg_rdata : ram_rdata.
- in_data change visible in IN reads 2 edges later; evt_in edge sets pending 3 edges after the input rises; irq follows pending by 1 cycle.
- Read and W1C of EVENT in the same cycle return pre-clear value.
- Reset asserted mid-pulse or mid-read: immediate clear, no completion.

## Structure
- Package mmio_pkg: window offsets (OFF_OUT, OFF_PULSE, OFF_IN, OFF_EVENT, OFF_MASK), window size 64, parameter range checks.
- Sub-module sync2 (two-flop synchroniser, WIDTH parameter), instantiated for in_data and evt_in.

## Test plan
- Reset low with evt_in=0 -> all outputs 0; store 0xDEADBEEF to BASE+1 -> out_data[63:32]=0xDEADBEEF next cycle, ram_we stays 0, read back returns it.
- Store/load to 0x010 (outside window) -> ram_we=1, bus_rdata equals RAM data.
- PULSE_LEN=3: write 0x5 to BASE+0x10 -> pulse_out[0],[2] high exactly 3 cycles; retrigger on cycle 2 -> high 5 cycles total.
- evt_in[3] rises with MASK=0x08 -> EVENT reads 0x08 after 3 edges, irq=1 next cycle; write 0x08 to EVENT -> pending and irq clear.
- New edge on evt_in[3] coinciding with W1C of bit 3 -> bit stays 1.
- in_data[31:0]=0x12345678 -> IN[0] read returns it 2 edges later; unmapped offset 0x3F reads 0; reset mid-pulse drops pulse_out immediately.
